// File: rtl/mac_pkg.sv
// Shared constants and types for the floating-point MAC datapath.
// The exception-flag path in round_pack is enabled by MAC_EXC_FLAGS_EN.
package mac_pkg;

  localparam int HALF_HID      = 20;
  localparam int SINGLE_HID    = 46;
  localparam int HALF_EMAX     = 31;
  localparam int SINGLE_EMAX   = 255;
  localparam int HALF_FRAC_W   = 10;
  localparam int SINGLE_FRAC_W = 23;

  // out_flags = {overflow, underflow, inexact, zero}
  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_OVERFLOW  = 3;

  typedef enum logic {
    FMT_HALF   = 1'b0,
    FMT_SINGLE = 1'b1
  } fmt_e;

endpackage

// File: rtl/round_pack_if.sv
// Handshake and data bundle between normalize, round_pack and the result consumer.
interface round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        nor_op;
  logic        nor_s;
  logic [7:0]  nor_e;
  logic [49:0] nor_m;
  logic        out_valid;
  logic        out_ready;
  logic        out_op;
  logic [31:0] out_res;
  logic [3:0]  out_flags;

  modport slave (
    input  in_valid, nor_op, nor_s, nor_e, nor_m, out_ready,
    output in_ready, out_valid, out_op, out_res, out_flags
  );

  modport master (
    output in_valid, nor_op, nor_s, nor_e, nor_m, out_ready,
    input  in_ready, out_valid, out_op, out_res, out_flags
  );
endinterface

// File: rtl/rne_round.sv
// Combinational round-to-nearest-even decision: extracts the fraction and
// derives the increment, inexact and zero indications for half or single.
module rne_round
  import mac_pkg::*;
(
  input  fmt_e                     op,
  input  logic [49:0]              m,
  output logic [SINGLE_FRAC_W-1:0] frac,
  output logic                     inc,
  output logic                     inexact,
  output logic                     is_zero
);

  logic lsb;
  logic guard;
  logic sticky;

  // Bits above the hidden one are guaranteed zero by normalize.
  logic unused_hi;
  assign unused_hi = ^m[49:47];

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    lsb     = 1'b0;
    guard   = 1'b0;
    sticky  = 1'b0;
    frac    = '0;
    is_zero = 1'b1;
    if (op == FMT_SINGLE) begin
      lsb     = m[23];
      guard   = m[22];
      sticky  = |m[21:0];
      frac    = m[45:23];
      is_zero = ~m[SINGLE_HID];
    end else begin
      lsb     = m[10];
      guard   = m[9];
      sticky  = |m[8:0];
      frac    = {13'b0, m[19:10]};
      is_zero = ~m[HALF_HID];
    end
    inc     = guard & (lsb | sticky);
    inexact = guard | sticky;
  end

endmodule

// File: rtl/round_pack.sv
// Two-stage round/pack pipeline producing IEEE half or single results.
// Define MAC_EXC_FLAGS_EN to compute and register out_flags; otherwise it is 0.
module round_pack
  import mac_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  round_pack_if.slave   bus
);

  logic                     advance;
  logic [SINGLE_FRAC_W-1:0] r_frac;
  logic                     r_inc;
  logic                     r_nx;
  logic                     r_zero;

  logic                     s1_valid_q, s1_valid_d;
  fmt_e                     s1_op_q,    s1_op_d;
  logic                     s1_s_q,     s1_s_d;
  logic [7:0]               s1_e_q,     s1_e_d;
  logic [SINGLE_FRAC_W-1:0] s1_frac_q,  s1_frac_d;
  logic                     s1_inc_q,   s1_inc_d;
  logic                     s1_zero_q,  s1_zero_d;
  logic                     s1_flush_q, s1_flush_d;

  logic                     out_valid_q, out_valid_d;
  logic                     out_op_q,    out_op_d;
  logic [31:0]              out_res_q,   out_res_d;

  logic [11:0]              sum_h;
  logic [24:0]              sum_s;
  logic                     carry;
  logic [8:0]               e_rnd;
  logic                     ovf;
  logic [31:0]              res;

  rne_round u_rne (
    .op      (fmt_e'(bus.nor_op)),
    .m       (bus.nor_m),
    .frac    (r_frac),
    .inc     (r_inc),
    .inexact (r_nx),
    .is_zero (r_zero)
  );

  assign advance      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = advance;

  // S2 datapath: add the increment below the hidden one, then pack.
  always_comb begin
    sum_h = {1'b0, 1'b1, s1_frac_q[HALF_FRAC_W-1:0]} + 12'(s1_inc_q);
    sum_s = {1'b0, 1'b1, s1_frac_q} + 25'(s1_inc_q);
    carry = (s1_op_q == FMT_SINGLE) ? sum_s[24] : sum_h[11];
    e_rnd = {1'b0, s1_e_q} + 9'(carry);
    ovf   = (s1_op_q == FMT_SINGLE) ? (e_rnd >= 9'(SINGLE_EMAX)) : (e_rnd >= 9'(HALF_EMAX));
    if (s1_zero_q || s1_flush_q) begin
      res = (s1_op_q == FMT_SINGLE) ? {s1_s_q, 31'b0} : {16'b0, s1_s_q, 15'b0};
    end else if (ovf) begin
      res = (s1_op_q == FMT_SINGLE) ? {s1_s_q, 8'hFF, 23'b0} : {16'b0, s1_s_q, 5'h1F, 10'b0};
    end else if (s1_op_q == FMT_SINGLE) begin
      res = {s1_s_q, e_rnd[7:0], sum_s[22:0]};
    end else begin
      res = {16'b0, s1_s_q, e_rnd[4:0], sum_h[9:0]};
    end
  end

  // The hidden-one position of each sum only matters through the carry.
  logic unused_hid;
  assign unused_hid = sum_s[23] ^ sum_h[10];

`ifdef MAC_EXC_FLAGS_EN
  logic       s1_nx_q, s1_nx_d;
  logic [3:0] out_flags_q, out_flags_d;
  logic [3:0] flags;

  always_comb begin
    flags = '0;
    if (s1_zero_q) begin
      flags[FLAG_ZERO] = 1'b1;
    end else if (s1_flush_q) begin
      flags[FLAG_ZERO]      = 1'b1;
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else if (ovf) begin
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      flags[FLAG_INEXACT] = s1_nx_q;
    end
    s1_nx_d     = s1_nx_q;
    out_flags_d = out_flags_q;
    if (advance) begin
      if (bus.in_valid) s1_nx_d = r_nx;
      if (s1_valid_q)   out_flags_d = flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_nx_q     <= 1'b0;
      out_flags_q <= '0;
    end else begin
      s1_nx_q     <= s1_nx_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.out_flags = out_flags_q;
`else
  logic unused_nx;
  assign unused_nx     = r_nx;
  assign bus.out_flags = 4'b0000;
`endif

  // Both stages advance together; a stalled output freezes the whole pipe.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_s_d      = s1_s_q;
    s1_e_d      = s1_e_q;
    s1_frac_d   = s1_frac_q;
    s1_inc_d    = s1_inc_q;
    s1_zero_d   = s1_zero_q;
    s1_flush_d  = s1_flush_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_res_d   = out_res_q;
    if (advance) begin
      s1_valid_d  = bus.in_valid;
      out_valid_d = s1_valid_q;
      if (bus.in_valid) begin
        s1_op_d    = fmt_e'(bus.nor_op);
        s1_s_d     = bus.nor_s;
        s1_e_d     = bus.nor_e;
        s1_frac_d  = r_frac;
        s1_inc_d   = r_inc;
        s1_zero_d  = r_zero;
        s1_flush_d = ~r_zero & (bus.nor_e == 8'd0);
      end
      if (s1_valid_q) begin
        out_op_d  = s1_op_q;
        out_res_d = res;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too so the outputs read 0 out of reset.
      s1_valid_q  <= 1'b0;
      s1_op_q     <= FMT_HALF;
      s1_s_q      <= 1'b0;
      s1_e_q      <= '0;
      s1_frac_q   <= '0;
      s1_inc_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_flush_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_op_q    <= 1'b0;
      out_res_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_s_q      <= s1_s_d;
      s1_e_q      <= s1_e_d;
      s1_frac_q   <= s1_frac_d;
      s1_inc_q    <= s1_inc_d;
      s1_zero_q   <= s1_zero_d;
      s1_flush_q  <= s1_flush_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_res_q   <= out_res_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_res   = out_res_q;

endmodule

// File: tb/tb_round_pack.sv
// Scoreboard bench for round_pack: directed plan cases, backpressure, mid-stream
// reset and randomized traffic against an arithmetic rounding model.
module tb_round_pack;
  import mac_pkg::*;

  typedef struct packed {
    logic        op;
    logic [3:0]  flags;
    logic [31:0] res;
  } out_t;

  typedef struct {
    out_t o;
    int   cyc;
    bit   chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_pack_if bus ();

  round_pack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   n_out   = 0;
  int   rst_cnt = 0;
  int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
  bit   rnd_rdy  = 1'b1;

  assign bus.out_ready = (rdy_mode == 0) || (rdy_mode == 2 && rnd_rdy);

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);
  always @(posedge rst) rst_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] fl(input logic [3:0] f);
`ifdef MAC_EXC_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  function automatic out_t mk(input logic op, input logic [3:0] f, input logic [31:0] r);
    out_t o;
    o.op    = op;
    o.flags = fl(f);
    o.res   = r;
    return o;
  endfunction

  // Reference: value-level round-half-even on the bits below the fraction.
  function automatic out_t model(input logic op, input logic s, input logic [7:0] e,
                                 input logic [49:0] m);
    int hid, fw, emax, sp, er, sh;
    longint unsigned mv, q, rem, halfw;
    bit up, nx;
    hid  = op ? SINGLE_HID    : HALF_HID;
    fw   = op ? SINGLE_FRAC_W : HALF_FRAC_W;
    emax = op ? SINGLE_EMAX   : HALF_EMAX;
    sp   = op ? 31 : 15;
    sh   = hid - fw;
    mv   = 64'(m);
    if (((mv >> hid) & 64'd1) == 64'd0)
      return mk(op, 4'b0001, 32'(s) << sp);
    if (e == 8'd0)
      return mk(op, 4'b0111, 32'(s) << sp);
    q     = mv >> sh;
    rem   = mv & ((64'd1 << sh) - 64'd1);
    halfw = 64'd1 << (sh - 1);
    nx    = (rem != 64'd0);
    up    = (rem > halfw) || (rem == halfw && q[0]);
    q     = q + 64'(up);
    er    = int'(e);
    if (q >= (64'd2 << fw)) begin
      er++;
      q = q >> 1;
    end
    if (er >= emax)
      return mk(op, 4'b1010, (32'(s) << sp) | (32'(emax) << fw));
    return mk(op, nx ? 4'b0010 : 4'b0000,
              (32'(s) << sp) | (32'(er) << fw) | 32'(q & ((64'd1 << fw) - 64'd1)));
  endfunction

  // Drive a word at a falling edge and hold it until accepted; returns at a falling edge.
  task automatic send(input logic op, input logic s, input logic [7:0] e, input logic [49:0] m,
                      input out_t exp, input bit lat);
    exp_t it;
    bus.in_valid = 1'b1;
    bus.nor_op   = op;
    bus.nor_s    = s;
    bus.nor_e    = e;
    bus.nor_m    = m;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (bus.in_ready) begin
        it.o       = exp;
        it.cyc     = cyc;
        it.chk_lat = lat;
        sb.push_back(it);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
  endtask

  task automatic sendm(input logic op, input logic s, input logic [7:0] e, input logic [49:0] m);
    send(op, s, e, m, model(op, s, e, m), 1'b0);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rand();
    logic op, s;
    logic [7:0] e;
    int hid, fw, emax, sh;
    longint unsigned low;
    op   = 1'($urandom_range(0, 1));
    s    = 1'($urandom);
    hid  = op ? SINGLE_HID    : HALF_HID;
    fw   = op ? SINGLE_FRAC_W : HALF_FRAC_W;
    emax = op ? SINGLE_EMAX   : HALF_EMAX;
    sh   = hid - fw;
    case ($urandom_range(0, 7))
      0:       e = 8'd0;
      1:       e = 8'd1;
      2:       e = 8'(emax - 1);
      3:       e = 8'(emax - 2);
      4:       e = 8'($urandom);
      default: e = 8'($urandom_range(1, emax - 1));
    endcase
    low = {$urandom, $urandom} & ((64'd1 << hid) - 64'd1);
    if ($urandom_range(0, 3) == 0)
      low = (low & ~((64'd1 << sh) - 64'd1)) | (64'd1 << (sh - 1));
    if ($urandom_range(0, 7) == 0)
      low = (64'd1 << hid) - 64'd1;
    if ($urandom_range(0, 15) != 0)
      low = low | (64'd1 << hid);
    sendm(op, s, e, 50'(low));
  endtask

  // Monitor: pops and compares whenever a result is consumed; checks hold stability.
  initial begin : monitor
    exp_t it;
    out_t cur, held_v;
    bit   held;
    int   held_rst;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cur = {bus.out_op, bus.out_flags, bus.out_res};
      if (!rst && bus.out_valid) begin
        if (held && held_rst == rst_cnt)
          check("hold_stable", 64'(cur), 64'(held_v));
        held = 1'b0;
        if (bus.out_ready) begin
          n_out++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", cur);
          end else begin
            it = sb.pop_front();
            check("result", 64'(cur), 64'(it.o));
            if (it.chk_lat) check("latency", 64'(cyc - it.cyc), 64'd2);
          end
        end else begin
          held     = 1'b1;
          held_v   = cur;
          held_rst = rst_cnt;
        end
      end else begin
        if (held && held_rst == rst_cnt)
          check("hold_valid", 64'(bus.out_valid), 64'd1);
        held = 1'b0;
      end
    end
  end

  initial begin : stim
    int base;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.nor_op   = 1'b0;
    bus.nor_s    = 1'b0;
    bus.nor_e    = '0;
    bus.nor_m    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_op",    64'(bus.out_op),    64'd0);
    check("rst_out_res",   64'(bus.out_res),   64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed plan cases, one at a time so latency is exact.
    send(0, 0, 8'd15,  50'd1 << 20,                        mk(0, 4'b0000, 32'h0000_3C00), 1); idle(3);
    send(1, 1, 8'd127, 50'd1 << 46,                        mk(1, 4'b0000, 32'hBF80_0000), 1); idle(3);
    send(0, 0, 8'd15,  (50'd1 << 20) | (50'd1 << 9),       mk(0, 4'b0010, 32'h0000_3C00), 1); idle(3);
    send(0, 0, 8'd15,  (50'd1 << 20) | (50'd3 << 9),       mk(0, 4'b0010, 32'h0000_3C02), 1); idle(3);
    send(0, 0, 8'd15,  50'hFFF << 9,                       mk(0, 4'b0010, 32'h0000_4000), 1); idle(3);
    send(1, 0, 8'd254, 50'h1FF_FFFF << 22,                 mk(1, 4'b1010, 32'h7F80_0000), 1); idle(3);
    send(0, 1, 8'd9,   50'd0,                              mk(0, 4'b0001, 32'h0000_8000), 1); idle(3);
    send(1, 1, 8'd0,   50'd1 << 46,                        mk(1, 4'b0111, 32'h8000_0000), 1); idle(3);
    send(0, 0, 8'd31,  50'd1 << 20,                        mk(0, 4'b1010, 32'h0000_7C00), 1); idle(3);
    send(0, 1, 8'd30,  50'h1FFFFF,                         mk(0, 4'b1010, 32'h0000_FC00), 1); idle(3);
    send(1, 0, 8'd1,   50'd1 << 46,                        mk(1, 4'b0000, 32'h0080_0000), 1); idle(3);
    send(1, 0, 8'd127, (50'd1 << 46) | (50'd1 << 23) | (50'd1 << 22),
                                                           mk(1, 4'b0010, 32'h3F80_0002), 1); idle(3);
    send(1, 0, 8'd127, (50'd1 << 46) | (50'd1 << 22) | 50'd1,
                                                           mk(1, 4'b0010, 32'h3F80_0001), 1); idle(3);

    // Backpressure: ready low for three cycles while four words stream in.
    fork
      begin
        rdy_mode = 1;
        @(negedge clk);
        #1 check("bp_in_ready_one_held", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        #1 check("bp_in_ready_two_held", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rdy_mode = 0;
      end
      begin
        sendm(0, 0, 8'd10,  (50'd1 << 20) | 50'h3_5A5A);
        sendm(1, 1, 8'd100, (50'd1 << 46) | 50'h12_3456_789A);
        sendm(0, 1, 8'd20,  (50'd1 << 20) | (50'd1 << 9));
        sendm(1, 0, 8'd200, (50'd1 << 46) | (50'd3 << 22));
        bus.in_valid = 1'b0;
      end
    join
    idle(10);
    check("bp_drain", 64'(sb.size()), 64'd0);

    // Reset with two words in flight: both are discarded.
    rdy_mode = 1;
    sendm(0, 0, 8'd12, (50'd1 << 20) | 50'h1234);
    sendm(1, 0, 8'd90, (50'd1 << 46) | 50'h5555);
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1 check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    base = n_out;
    @(negedge clk);
    rst      = 1'b0;
    rdy_mode = 0;
    idle(6);
    check("post_rst_quiet", 64'(n_out - base), 64'd0);

    // Randomized traffic with random backpressure and input gaps.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      send_rand();
    end
    bus.in_valid = 1'b0;
    rdy_mode     = 0;
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    idle(3);
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
